// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// byte width and the log2 helper used to size counters.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam int UART_BYTE_W = 8;

    // Ceiling log2; returns 0 for v <= 1, so callers clamp to at least one bit.
    function automatic int clog2(input longint v);
        int r;
        r = 0;
        while ((longint'(1) << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ, reported both one-hot and as an index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [PW-1:0]    win_idx
);

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                win_idx = PW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // win_idx defaults to 0 when nothing is pending, and req[0] is then low.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_win
            assign win[gi] = req[gi] && (win_idx == PW'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender among N_REQ byte producers,
// with per-requester capture/completion strobes and a no-ack watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic [N_REQ-1:0]               req,
    input  logic [UART_BYTE_W*N_REQ-1:0]   data,
    output logic [N_REQ-1:0]               gnt,
    output logic [N_REQ-1:0]               done,
    output logic                           busy,
    output logic                           timeout_err,
    output logic                           snd_req,
    output logic [UART_BYTE_W-1:0]         snd_data,
    input  logic                           snd_ack
);

    localparam int PW = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam int TW = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

    arb_state_t             state_reg, state_next;
    logic [PW-1:0]          ptr_reg, ptr_next;
    logic [PW-1:0]          cur_reg, cur_next;
    logic [TW-1:0]          timer_reg, timer_next;
    logic [N_REQ-1:0]       gnt_reg, gnt_next;
    logic [N_REQ-1:0]       done_reg, done_next;
    logic                   terr_reg, terr_next;
    logic                   snd_req_reg, snd_req_next;
    logic [UART_BYTE_W-1:0] snd_data_reg, snd_data_next;

    logic [N_REQ-1:0]       win;
    logic [PW-1:0]          win_idx;
    logic [N_REQ-1:0]       cur_oh;
    logic [PW-1:0]          ptr_adv;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_reg),
        .win     (win),
        .win_idx (win_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cur_oh
            assign cur_oh[gi] = (cur_reg == PW'(gi));
        end
    endgenerate

    // Priority moves just past the requester that was last served.
    assign ptr_adv = (cur_reg == PW'(N_REQ - 1)) ? '0 : cur_reg + PW'(1);

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        cur_next      = cur_reg;
        timer_next    = timer_reg;
        gnt_next      = '0;
        done_next     = '0;
        terr_next     = 1'b0;
        snd_req_next  = 1'b0;
        snd_data_next = snd_data_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    cur_next      = win_idx;
                    snd_data_next = data[win_idx*UART_BYTE_W +: UART_BYTE_W];
                    gnt_next      = win;
                    snd_req_next  = 1'b1;
                    timer_next    = '0;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (snd_ack) begin
                    done_next  = cur_oh;
                    ptr_next   = ptr_adv;
                    state_next = IDLE;
                end else if ((TIMEOUT != 0) && (timer_reg == TW'(TIMEOUT - 1))) begin
                    terr_next  = 1'b1;
                    ptr_next   = ptr_adv;
                    state_next = IDLE;
                end else if (timer_reg != {TW{1'b1}}) begin
                    // Saturate so a disabled watchdog never sees the timer wrap.
                    timer_next = timer_reg + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            cur_reg      <= '0;
            timer_reg    <= '0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            terr_reg     <= 1'b0;
            snd_req_reg  <= 1'b0;
            snd_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cur_reg      <= cur_next;
            timer_reg    <= timer_next;
            gnt_reg      <= gnt_next;
            done_reg     <= done_next;
            terr_reg     <= terr_next;
            snd_req_reg  <= snd_req_next;
            snd_data_reg <= snd_data_next;
        end
    end

    assign gnt         = gnt_reg;
    assign done        = done_reg;
    assign busy        = (state_reg != IDLE);
    assign timeout_err = terr_reg;
    assign snd_req     = snd_req_reg;
    assign snd_data    = snd_data_reg;

endmodule
